// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// =============================================================================
// alu_issue_ctrl : valid/ready command front end for the 8-bit combinational ALU
// Rev 1.0 - initial release
// =============================================================================
module alu_issue_ctrl #(
  parameter int SETTLE = 1,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [7:0]       req_a_i,
  input  logic [7:0]       req_b_i,
  input  logic [3:0]       req_sel_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic [7:0]       alu_a_o,
  output logic [7:0]       alu_b_o,
  output logic [3:0]       alu_sel_o,
  input  logic [7:0]       alu_s_i,
  input  logic             alu_carry_i,
  input  logic             alu_ovf_i,
  input  logic             alu_zero_i,
  input  logic             alu_sign_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [7:0]       rsp_data_o,
  output logic [3:0]       rsp_flags_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             rsp_err_o,
  input  logic             status_clr_i,
  output logic [3:0]       status_o,
  output logic [CNT_W-1:0] op_count_o,
  output logic [7:0]       err_count_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE - 1);
  localparam logic [CNT_W-1:0] OP_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic             req_ready_q;
  logic [3:0]       settle_q;
  logic [TAG_W-1:0] tag_q;
  logic [7:0]       alu_a_q;
  logic [7:0]       alu_b_q;
  logic [3:0]       alu_sel_q;
  logic             rsp_valid_q;
  logic [7:0]       rsp_data_q;
  logic [3:0]       rsp_flags_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic             rsp_err_q;
  logic [3:0]       status_q;
  logic [CNT_W-1:0] op_count_q;
  logic [7:0]       err_count_q;

  logic [3:0]       alu_flags_d;
  logic [3:0]       status_base_d;
  logic [7:0]       err_count_d;

  assign alu_flags_d   = {alu_carry_i, alu_ovf_i, alu_zero_i, alu_sign_i};
  // A clear coinciding with a capture must leave only the new flags.
  assign status_base_d = status_clr_i ? 4'b0000 : status_q;
  assign err_count_d   = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      settle_q    <= '0;
      tag_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
      status_q    <= '0;
      op_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      if (status_clr_i) begin
        status_q <= 4'b0000;
      end
      case (state_q)
        S_IDLE: begin
          if (req_valid_i && req_ready_q) begin
            tag_q       <= req_tag_i;
            req_ready_q <= 1'b0;
            if (!req_sel_i[3]) begin
              alu_a_q   <= req_a_i;
              alu_b_q   <= req_b_i;
              alu_sel_q <= req_sel_i;
              settle_q  <= SETTLE_LOAD;
              state_q   <= S_WAIT;
            end else begin
              // Illegal opcode never touches the ALU; respond immediately.
              rsp_data_q  <= 8'h00;
              rsp_flags_q <= 4'b0000;
              rsp_tag_q   <= req_tag_i;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              err_count_q <= err_count_d;
              state_q     <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          if (settle_q == 4'd0) begin
            rsp_data_q  <= alu_s_i;
            rsp_flags_q <= alu_flags_d;
            rsp_tag_q   <= tag_q;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            status_q    <= status_base_d | alu_flags_d;
            op_count_q  <= op_count_q + OP_ONE;
            state_q     <= S_RESP;
          end else begin
            settle_q <= settle_q - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_sel_o   = alu_sel_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_flags_o = rsp_flags_q;
  assign rsp_tag_o   = rsp_tag_q;
  assign rsp_err_o   = rsp_err_q;
  assign status_o    = status_q;
  assign op_count_o  = op_count_q;
  assign err_count_o = err_count_q;

endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequential command front end for the 8-bit combinational ALU (ports A, B, Sel, S, Carry, Overflow, Zero, Sign). It accepts operation requests over a valid/ready handshake and drives registered operands and opcode into the ALU. After a programmable settle time it captures the result and the four flags, then returns a tagged response over a second valid/ready handshake. It also keeps sticky flag status and operation/error counters for software.

Parameters:
SETTLE, 1, cycles operands are held on the ALU before capture (legal range 1-15)
TAG_W, 4, width of request/response tag
CNT_W, 16, width of the wrapping op counter

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_a  in  8  operand A
req_b  in  8  operand B
req_sel  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL1, 7 SHR1; 8-15 illegal
req_tag  in  TAG_W  request tag
alu_a  out  8  to ALU A
alu_b  out  8  to ALU B
alu_sel  out  4  to ALU Sel
alu_s  in  8  from ALU S
alu_carry  in  1  from ALU Carry
alu_ovf  in  1  from ALU Overflow
alu_zero  in  1  from ALU Zero
alu_sign  in  1  from ALU Sign
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_data  out  8  captured result
rsp_flags  out  4  {carry, ovf, zero, sign}
rsp_tag  out  TAG_W  echoed tag
rsp_err  out  1  illegal opcode
status_clr  in  1  synchronous clear of sticky status
status  out  4  sticky OR of captured flags, same order as rsp_flags
op_count  out  CNT_W  legal ops completed, wraps
err_count  out  8  illegal ops, saturates at 0xFF

Behaviour:
- Reset (rst_n low, async): state IDLE. req_ready=1. All other outputs are 0: rsp_valid, rsp_data, rsp_flags, rsp_tag, rsp_err, alu_a, alu_b, alu_sel, status, op_count, err_count.
- Reset mid-operation drops any in-flight request; no response is produced.
- FSM: IDLE -> WAIT -> RESP -> IDLE.
- IDLE: req_ready=1. On req_valid&&req_ready:
  - Latch the tag.
  - Legal opcode (req_sel[3]==0): load alu_a/alu_b/alu_sel, load settle counter with SETTLE-1, go to WAIT.
  - Illegal opcode: leave ALU outputs unchanged. Load rsp_data=0, rsp_flags=0, rsp_err=1. Increment err_count (saturating). Go directly to RESP.
- WAIT: req_ready=0; counter decrements each cycle. In the cycle the counter is 0:
  - At that edge capture alu_s into rsp_data and the flags into rsp_flags; set rsp_err=0.
  - OR the captured flags into status; op_count+1 (wraps).
  - Go to RESP.
- Legal-op latency: accept at edge E, capture at edge E+SETTLE, rsp_valid high in the cycle after E+SETTLE.
- Illegal-op latency: rsp_valid high in the cycle after the accept edge.
- RESP: rsp_valid=1, req_ready=0. All rsp_* outputs are held stable until rsp_valid&&rsp_ready, then go to IDLE. rsp_valid drops the next cycle and rsp_* keep their last values.
- No back-to-back overlap:
  - Minimum legal-op period is SETTLE+2 cycles with rsp_ready tied high.
  - A request presented during WAIT/RESP waits (req_ready=0).
- alu_a/alu_b/alu_sel are registered and hold the last legal op indefinitely; they change only on a legal accept.
- status_clr:
  - Alone: status becomes 0 next edge.
  - Same edge as a capture: status becomes exactly the newly captured flags (clear applied before the OR).
- Counters and status are unaffected by rsp_ready stalls.

Test Plan:
- Reset with rst_n=0 mid-WAIT (SETTLE=3) -> all outputs 0 immediately, req_ready=1; no rsp_valid after release.
- ADD 0x7F+0x01, tag 5, SETTLE=1, rsp_ready=1 -> accept at edge E; rsp_valid in cycle after E+1; rsp_data=0x80, rsp_flags=0b0101 (C=0,V=1,Z=0,S=1), rsp_tag=5, op_count=1.
- SUB 0x05-0x05 with rsp_ready low for 4 cycles -> rsp_valid held 4+ cycles; rsp_data=0x00, zero flag=1 stable; one handshake only; req_ready=0 until it completes.
- Illegal sel=0xA, tag 3 -> rsp_valid one cycle after accept; rsp_err=1, rsp_data=0, alu_* unchanged; err_count=1; 300 illegal ops -> err_count=0xFF.
- Sticky status: ADD 0xFF+0x01 (C=1,Z=1) then AND 0x80&0x80 (S=1) -> status=0b1011. status_clr on the capture edge of SHR 0x02 -> status=0b0000.
- SETTLE=4: change ALU-model inputs during WAIT -> value captured is the one at edge E+4; op_count at 0xFFFF wraps to 0x0000 after one more legal op.
